// File: rtl/issue_pkg.sv
// Shared types and constants for the issue decoder: opcodes, ALU and memory-size codes, the decoded-lane record.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'h00, ALU_SUB  = 5'h01, ALU_SLL  = 5'h02, ALU_XOR  = 5'h03,
    ALU_SRL  = 5'h04, ALU_SRA  = 5'h05, ALU_OR   = 5'h06, ALU_AND  = 5'h07,
    ALU_SLT  = 5'h08, ALU_SLTU = 5'h09, ALU_BEQ  = 5'h0A, ALU_BNE  = 5'h0B,
    ALU_BLT  = 5'h0C, ALU_BGE  = 5'h0D, ALU_BLTU = 5'h0E, ALU_BGEU = 5'h0F,
    ALU_NOP  = 5'h1F
  } alu_opr_e;

  typedef enum logic [2:0] {
    MEM_B = 3'd0, MEM_H = 3'd1, MEM_W = 3'd2, MEM_BU = 3'd3, MEM_HU = 3'd4, MEM_D = 3'd5
  } mem_size_e;

  typedef struct packed {
    alu_opr_e  alu_opr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    mem_size_e mem_size;
    logic      reg_write_en;
    logic      rs2_en;
    logic      branch_en;
    logic      mem_read_en;
    logic      mem_write_en;
    logic      illegal;
  } lane_ctl_t;

  typedef enum logic {ST_ISSUE = 1'b0, ST_SPLIT = 1'b1} state_e;

  // Empty lane: NOP opcode, every address and enable zero.
  function automatic lane_ctl_t lane_nop();
    lane_ctl_t l;
    l = '0;
    l.alu_opr = ALU_NOP;
    return l;
  endfunction

  // True when lane b may not issue in the same group as the earlier lane a.
  function automatic logic lanes_conflict(input lane_ctl_t a, input lane_ctl_t b);
    logic raw, waw, mem, br;
    raw = a.reg_write_en && (a.rd != 5'd0) &&
          ((a.rd == b.rs1) || (b.rs2_en && (a.rd == b.rs2)));
    waw = a.reg_write_en && b.reg_write_en && (a.rd == b.rd) && (a.rd != 5'd0);
    mem = (a.mem_read_en || a.mem_write_en) && (b.mem_read_en || b.mem_write_en);
    br  = a.branch_en;
    return !a.illegal && !b.illegal && (raw || waw || mem || br);
  endfunction

endpackage

// File: rtl/lane_decode.sv
// Single-lane RV instruction decoder into a lane_ctl_t record; unknown encodings become an illegal NOP lane.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: i_inst (32-bit instruction), o_lane (decoded controls).
module lane_decode
  import issue_pkg::*;
(
  input  logic [31:0] i_inst,
  output lane_ctl_t   o_lane
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  lane_ctl_t  w_dec;
  lane_ctl_t  w_bad;
  logic       w_legal;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  always_comb begin
    w_bad         = lane_nop();
    w_bad.illegal = 1'b1;
  end

  always_comb begin
    w_dec   = lane_nop();
    w_legal = 1'b1;
    case (w_opcode)
      OP_R: begin
        w_dec.rd           = i_inst[11:7];
        w_dec.rs1          = i_inst[19:15];
        w_dec.rs2          = i_inst[24:20];
        w_dec.rs2_en       = 1'b1;
        w_dec.reg_write_en = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_dec.alu_opr = ALU_ADD;
          {7'b0100000, 3'b000}: w_dec.alu_opr = ALU_SUB;
          {7'b0000000, 3'b001}: w_dec.alu_opr = ALU_SLL;
          {7'b0000000, 3'b010}: w_dec.alu_opr = ALU_SLT;
          {7'b0000000, 3'b011}: w_dec.alu_opr = ALU_SLTU;
          {7'b0000000, 3'b100}: w_dec.alu_opr = ALU_XOR;
          {7'b0000000, 3'b101}: w_dec.alu_opr = ALU_SRL;
          {7'b0100000, 3'b101}: w_dec.alu_opr = ALU_SRA;
          {7'b0000000, 3'b110}: w_dec.alu_opr = ALU_OR;
          {7'b0000000, 3'b111}: w_dec.alu_opr = ALU_AND;
          default:              w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_dec.rd           = i_inst[11:7];
        w_dec.rs1          = i_inst[19:15];
        w_dec.reg_write_en = 1'b1;
        case (w_funct3)
          3'b000: w_dec.alu_opr = ALU_ADD;
          3'b010: w_dec.alu_opr = ALU_SLT;
          3'b011: w_dec.alu_opr = ALU_SLTU;
          3'b100: w_dec.alu_opr = ALU_XOR;
          3'b110: w_dec.alu_opr = ALU_OR;
          3'b111: w_dec.alu_opr = ALU_AND;
          // Shift immediates: the upper immediate bits select logical vs arithmetic.
          3'b001: begin
            w_dec.alu_opr = ALU_SLL;
            w_legal       = (w_funct7 == 7'b0000000);
          end
          default: begin
            if (w_funct7 == 7'b0000000)      w_dec.alu_opr = ALU_SRL;
            else if (w_funct7 == 7'b0100000) w_dec.alu_opr = ALU_SRA;
            else                             w_legal = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        w_dec.rd           = i_inst[11:7];
        w_dec.rs1          = i_inst[19:15];
        w_dec.reg_write_en = 1'b1;
        w_dec.mem_read_en  = 1'b1;
        w_dec.alu_opr      = ALU_ADD;
        case (w_funct3)
          3'b000:  w_dec.mem_size = MEM_B;
          3'b001:  w_dec.mem_size = MEM_H;
          3'b010:  w_dec.mem_size = MEM_W;
          3'b011:  w_dec.mem_size = MEM_D;
          3'b100:  w_dec.mem_size = MEM_BU;
          3'b101:  w_dec.mem_size = MEM_HU;
          default: w_legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        w_dec.rs1          = i_inst[19:15];
        w_dec.rs2          = i_inst[24:20];
        w_dec.rs2_en       = 1'b1;
        w_dec.mem_write_en = 1'b1;
        w_dec.alu_opr      = ALU_ADD;
        case (w_funct3)
          3'b000:  w_dec.mem_size = MEM_B;
          3'b001:  w_dec.mem_size = MEM_H;
          3'b010:  w_dec.mem_size = MEM_W;
          3'b011:  w_dec.mem_size = MEM_D;
          default: w_legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        w_dec.rs1       = i_inst[19:15];
        w_dec.rs2       = i_inst[24:20];
        w_dec.rs2_en    = 1'b1;
        w_dec.branch_en = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.alu_opr = ALU_BEQ;
          3'b001:  w_dec.alu_opr = ALU_BNE;
          3'b100:  w_dec.alu_opr = ALU_BLT;
          3'b101:  w_dec.alu_opr = ALU_BGE;
          3'b110:  w_dec.alu_opr = ALU_BLTU;
          3'b111:  w_dec.alu_opr = ALU_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign o_lane = w_legal ? w_dec : w_bad;

endmodule

// File: rtl/issue_decoder.sv
// Registered LANES-wide decode stage; splits a fetch bundle into hazard-free issue groups.
// Latency: 1 cycle from bundle accept to first group; one extra cycle per additional group.
// Backpressure: output register stalls on !out_ready; in_ready drops while a bundle is being split or during flush.
// Ports: clk/rst_n, flush; in_valid/in_ready/in_inst (bundle in); out_valid/out_ready plus per-lane
//        decoded controls (group out); split_cnt (saturating count of split bundles). LANES legal range 2..4.
module issue_decoder
  import issue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int OPR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*LANES-1:0]    in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [OPR_W*LANES-1:0] out_alu_opr,
  output logic [5*LANES-1:0]     out_rd,
  output logic [5*LANES-1:0]     out_rs1,
  output logic [5*LANES-1:0]     out_rs2,
  output logic [3*LANES-1:0]     out_mem_size,
  output logic [LANES-1:0]       out_reg_write_en,
  output logic [LANES-1:0]       out_rs2_en,
  output logic [LANES-1:0]       out_branch_en,
  output logic [LANES-1:0]       out_mem_read_en,
  output logic [LANES-1:0]       out_mem_write_en,
  output logic [LANES-1:0]       out_illegal,
  output logic [CNT_W-1:0]       split_cnt
);

  state_e           r_state, w_state_nxt;
  lane_ctl_t        w_dec  [LANES];
  lane_ctl_t        w_src  [LANES];
  lane_ctl_t        r_hold [LANES];
  lane_ctl_t        r_out  [LANES];
  logic [LANES-1:0] r_hold_mask, r_out_mask;
  logic [LANES-1:0] w_pending, w_conflict, w_issue, w_rem;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_split_cnt;
  logic             w_slot_free, w_accept, w_advance, w_load, w_stop;

  for (genvar j = 0; j < LANES; j++) begin : g_dec
    lane_decode u_lane_decode (
      .i_inst (in_inst[32*j +: 32]),
      .o_lane (w_dec[j])
    );
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == ST_ISSUE) && w_slot_free && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_advance   = (r_state == ST_SPLIT) && w_slot_free && !flush;
  assign w_load      = w_accept || w_advance;

  // Group selection: the first pending lane that hits any earlier pending lane
  // and everything above it wait; lane positions never move.
  always_comb begin
    w_pending = (r_state == ST_SPLIT) ? r_hold_mask : {LANES{1'b1}};
    for (int j = 0; j < LANES; j++) begin
      w_src[j] = (r_state == ST_SPLIT) ? r_hold[j] : w_dec[j];
    end
    w_conflict = '0;
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (w_pending[i] && w_pending[j] && lanes_conflict(w_src[i], w_src[j])) begin
          w_conflict[j] = 1'b1;
        end
      end
    end
    w_stop  = 1'b0;
    w_issue = '0;
    for (int j = 0; j < LANES; j++) begin
      if (w_conflict[j]) w_stop = 1'b1;
      w_issue[j] = w_pending[j] && !w_stop;
    end
    w_rem = w_pending & ~w_issue;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_ISSUE;
    end else begin
      case (r_state)
        ST_ISSUE: if (w_accept && (|w_rem))   w_state_nxt = ST_SPLIT;
        ST_SPLIT: if (w_advance && !(|w_rem)) w_state_nxt = ST_ISSUE;
        default:  w_state_nxt = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ISSUE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_hold_mask <= '0;
      r_split_cnt <= '0;
      for (int j = 0; j < LANES; j++) begin
        r_out[j]  <= lane_nop();
        r_hold[j] <= lane_nop();
      end
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
        r_out_mask  <= '0;
        r_hold_mask <= '0;
        for (int j = 0; j < LANES; j++) r_out[j] <= lane_nop();
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_mask  <= w_issue;
        r_hold_mask <= w_rem;
        for (int j = 0; j < LANES; j++) begin
          r_out[j] <= w_issue[j] ? w_src[j] : lane_nop();
        end
        // Held lanes are captured only when a fresh bundle actually splits.
        if (w_accept && (|w_rem)) begin
          for (int j = 0; j < LANES; j++) r_hold[j] <= w_dec[j];
          if (r_split_cnt != {CNT_W{1'b1}}) r_split_cnt <= r_split_cnt + 1'b1;
        end
      end else if (w_slot_free) begin
        // Slot drained with nothing new: return lanes to the idle NOP pattern.
        r_out_valid <= 1'b0;
        r_out_mask  <= '0;
        for (int j = 0; j < LANES; j++) r_out[j] <= lane_nop();
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_lane_valid = r_out_mask;
  assign split_cnt      = r_split_cnt;

  for (genvar j = 0; j < LANES; j++) begin : g_out
    assign out_alu_opr[OPR_W*j +: OPR_W] = OPR_W'(r_out[j].alu_opr);
    assign out_rd[5*j +: 5]              = r_out[j].rd;
    assign out_rs1[5*j +: 5]             = r_out[j].rs1;
    assign out_rs2[5*j +: 5]             = r_out[j].rs2;
    assign out_mem_size[3*j +: 3]        = r_out[j].mem_size;
    assign out_reg_write_en[j]           = r_out[j].reg_write_en;
    assign out_rs2_en[j]                 = r_out[j].rs2_en;
    assign out_branch_en[j]              = r_out[j].branch_en;
    assign out_mem_read_en[j]            = r_out[j].mem_read_en;
    assign out_mem_write_en[j]           = r_out[j].mem_write_en;
    assign out_illegal[j]                = r_out[j].illegal;
  end

endmodule

// File: tb/tb_issue_decoder.sv
// Self-checking bench for issue_decoder (LANES=2): scoreboard of expected issue groups plus directed checks.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, split stalls and flush.
module tb_issue_decoder;

  localparam int LANES = 2;
  localparam int OPR_W = 5;
  localparam int CNT_W = 16;

  // Expected lane record: {alu, rd, rs1, rs2, size, rwe, rs2_en, br, mrd, mwr, ill}
  localparam logic [28:0] NOPL = {5'h1F, 5'd0, 5'd0, 5'd0, 3'd0, 6'b000000};
  localparam logic [28:0] ADD1 = {5'h00, 5'd1, 5'd2, 5'd3, 3'd0, 6'b110000};
  localparam logic [28:0] ADD6 = {5'h00, 5'd6, 5'd7, 5'd8, 3'd0, 6'b110000};
  localparam logic [28:0] ADD4 = {5'h00, 5'd4, 5'd1, 5'd5, 3'd0, 6'b110000};
  localparam logic [28:0] LW9  = {5'h00, 5'd9, 5'd2, 5'd0, 3'd2, 6'b100100};
  localparam logic [28:0] SW3  = {5'h00, 5'd0, 5'd2, 5'd3, 3'd2, 6'b010010};
  localparam logic [28:0] BEQ  = {5'h0A, 5'd0, 5'd1, 5'd2, 3'd0, 6'b011000};
  localparam logic [28:0] ILL  = {5'h1F, 5'd0, 5'd0, 5'd0, 3'd0, 6'b000001};

  localparam logic [63:0] B_IND = {32'h00838333, 32'h003100B3};
  localparam logic [63:0] B_RAW = {32'h00508233, 32'h003100B3};
  localparam logic [63:0] B_MEM = {32'h00312023, 32'h00012483};
  localparam logic [63:0] B_BR  = {32'h00838333, 32'h00208063};
  localparam logic [63:0] B_ILL = {32'h00838333, 32'hFFFFFFFF};

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [32*LANES-1:0]    in_inst = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES-1:0]       out_lane_valid;
  logic [OPR_W*LANES-1:0] out_alu_opr;
  logic [5*LANES-1:0]     out_rd, out_rs1, out_rs2;
  logic [3*LANES-1:0]     out_mem_size;
  logic [LANES-1:0]       out_reg_write_en, out_rs2_en, out_branch_en;
  logic [LANES-1:0]       out_mem_read_en, out_mem_write_en, out_illegal;
  logic [CNT_W-1:0]       split_cnt;

  issue_decoder #(.LANES(LANES), .OPR_W(OPR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_inst          (in_inst),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_lane_valid   (out_lane_valid),
    .out_alu_opr      (out_alu_opr),
    .out_rd           (out_rd),
    .out_rs1          (out_rs1),
    .out_rs2          (out_rs2),
    .out_mem_size     (out_mem_size),
    .out_reg_write_en (out_reg_write_en),
    .out_rs2_en       (out_rs2_en),
    .out_branch_en    (out_branch_en),
    .out_mem_read_en  (out_mem_read_en),
    .out_mem_write_en (out_mem_write_en),
    .out_illegal      (out_illegal),
    .split_cnt        (split_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [59:0] sb_q[$];

  logic [28:0] act_l [LANES];
  logic [59:0] act_grp;
  for (genvar j = 0; j < LANES; j++) begin : g_act
    assign act_l[j] = {out_alu_opr[OPR_W*j +: OPR_W], out_rd[5*j +: 5], out_rs1[5*j +: 5],
                       out_rs2[5*j +: 5], out_mem_size[3*j +: 3], out_reg_write_en[j],
                       out_rs2_en[j], out_branch_en[j], out_mem_read_en[j],
                       out_mem_write_en[j], out_illegal[j]};
  end
  assign act_grp = {out_lane_valid, act_l[1], act_l[0]};

  function automatic logic [59:0] grp(input logic [1:0] m, input logic [28:0] l1, input logic [28:0] l0);
    return {m, l1, l0};
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Every group the DUT hands over is matched against the oldest expectation;
  // an empty queue yields an all-zero expectation, which no real group matches.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [59:0] exp;
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 60'd0;
      chk_eq("group", 64'(act_grp), 64'(exp));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the bundle.
  task automatic send(input logic [63:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = b;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk_eq("send_timeout", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    step();
    chk_eq({tag, "_drain"}, 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    int c0;
    #12;
    chk_eq("rst_group", 64'(act_grp), 64'(grp(2'b00, NOPL, NOPL)));
    chk_eq("rst_out_valid", 64'(out_valid), 64'(0));
    chk_eq("rst_in_ready", 64'(in_ready), 64'(1));
    chk_eq("rst_split_cnt", 64'(split_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Independent pair, then three back-to-back for throughput.
    sb_q.push_back(grp(2'b11, ADD6, ADD1));
    send(B_IND);
    @(negedge clk);
    chk_eq("ind_in_ready", 64'(in_ready), 64'(1));
    step();
    c0 = cyc;
    repeat (3) sb_q.push_back(grp(2'b11, ADD6, ADD1));
    repeat (3) send(B_IND);
    chk_eq("throughput_cycles", 64'(cyc - c0), 64'(3));
    drain("ind");
    chk_eq("ind_split_cnt", 64'(split_cnt), 64'(0));

    // RAW pair splits into lane0 then lane1.
    sb_q.push_back(grp(2'b01, NOPL, ADD1));
    sb_q.push_back(grp(2'b10, ADD4, NOPL));
    send(B_RAW);
    @(negedge clk);
    chk_eq("raw_in_ready_split", 64'(in_ready), 64'(0));
    step();
    drain("raw");
    chk_eq("raw_split_cnt", 64'(split_cnt), 64'(1));

    // Two memory ops never share a group.
    sb_q.push_back(grp(2'b01, NOPL, LW9));
    sb_q.push_back(grp(2'b10, SW3, NOPL));
    send(B_MEM);
    drain("mem");
    chk_eq("mem_split_cnt", 64'(split_cnt), 64'(2));

    // Branch first, with a 3-cycle downstream stall and a competing bundle offered.
    out_ready = 1'b0;
    sb_q.push_back(grp(2'b01, NOPL, BEQ));
    sb_q.push_back(grp(2'b10, ADD6, NOPL));
    send(B_BR);
    in_valid = 1'b1;
    in_inst  = B_IND;
    repeat (3) begin
      @(negedge clk);
      chk_eq("stall_group", 64'(act_grp), 64'(grp(2'b01, NOPL, BEQ)));
      chk_eq("stall_out_valid", 64'(out_valid), 64'(1));
      chk_eq("stall_in_ready", 64'(in_ready), 64'(0));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("br");
    chk_eq("br_split_cnt", 64'(split_cnt), 64'(3));

    // Illegal lane issues alongside a legal one without splitting.
    sb_q.push_back(grp(2'b11, ADD6, ILL));
    send(B_ILL);
    drain("ill");
    chk_eq("ill_split_cnt", 64'(split_cnt), 64'(3));

    // Flush drops a bundle offered in the same cycle.
    in_valid = 1'b1;
    in_inst  = B_IND;
    flush    = 1'b1;
    @(negedge clk);
    chk_eq("flush_in_ready", 64'(in_ready), 64'(0));
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_eq("flush_drop_out_valid", 64'(out_valid), 64'(0));
    step();

    // Flush during a split: the held lane never appears.
    sb_q.push_back(grp(2'b01, NOPL, ADD1));
    send(B_RAW);
    flush = 1'b1;
    @(negedge clk);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk_eq("fsplit_out_valid", 64'(out_valid), 64'(0));
    chk_eq("fsplit_in_ready", 64'(in_ready), 64'(1));
    step();
    repeat (3) step();
    chk_eq("fsplit_split_cnt", 64'(split_cnt), 64'(4));
    chk_eq("fsplit_sb_empty", 64'(sb_q.size()), 64'(0));

    // Asynchronous reset in the middle of a split.
    sb_q.push_back(grp(2'b01, NOPL, ADD1));
    send(B_RAW);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_group", 64'(act_grp), 64'(grp(2'b00, NOPL, NOPL)));
    chk_eq("arst_out_valid", 64'(out_valid), 64'(0));
    chk_eq("arst_in_ready", 64'(in_ready), 64'(1));
    chk_eq("arst_split_cnt", 64'(split_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk_eq("arst_sb_empty", 64'(sb_q.size()), 64'(0));
    chk_eq("arst_out_valid_after", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
